// File: rtl/lifo_drain_streamer_pkg.sv
// Shared types for the LIFO drain streamer: FSM state encoding and the
// buffer-entry layout {last, data}.
package lifo_drain_streamer_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StPopping,
    StFlushing
  } state_e;

  // A buffer entry is packed {last, data}: the last flag sits directly above the data MSB.
  function automatic int unsigned entry_width(int unsigned data_width);
    return data_width + 1;
  endfunction

endpackage

// File: rtl/lifo_drain_buffer.sv
// Two-entry in-order buffer between the LIFO pop port and the output stream.
// The head is released only once its last status is settled.
module lifo_drain_buffer
  import lifo_drain_streamer_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             push_last,
  input  logic             pop,
  input  logic             tag_tail_last,
  output logic             head_valid,
  output logic [WIDTH-1:0] head_data,
  output logic             head_last,
  output logic [1:0]       count
);

  localparam int unsigned EntryWidth = entry_width(WIDTH);

  logic [EntryWidth-1:0] slot_q [2];
  logic [EntryWidth-1:0] slot_d [2];
  logic [1:0]            count_q, count_d;

  always_comb begin
    slot_d  = slot_q;
    count_d = count_q;
    if (pop && count_q != 2'd0) begin
      slot_d[0] = slot_q[1];
      count_d   = count_q - 2'd1;
    end
    // Tagging targets the youngest entry left after any same-cycle pop.
    if (tag_tail_last) begin
      if (count_d == 2'd2) begin
        slot_d[1][EntryWidth-1] = 1'b1;
      end else if (count_d == 2'd1) begin
        slot_d[0][EntryWidth-1] = 1'b1;
      end
    end
    if (push && count_d != 2'd2) begin
      if (count_d == 2'd0) begin
        slot_d[0] = {push_last, push_data};
      end else begin
        slot_d[1] = {push_last, push_data};
      end
      count_d = count_d + 2'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      slot_q[0] <= '0;
      slot_q[1] <= '0;
      count_q   <= 2'd0;
    end else begin
      slot_q[0] <= slot_d[0];
      slot_q[1] <= slot_d[1];
      count_q   <= count_d;
    end
  end

  assign head_data  = slot_q[0][WIDTH-1:0];
  assign head_last  = slot_q[0][EntryWidth-1];
  assign head_valid = (count_q == 2'd2) || (count_q == 2'd1 && slot_q[0][EntryWidth-1]);
  assign count      = count_q;

endmodule

// File: rtl/lifo_drain_streamer.sv
// Drains up to drain_length entries from the LIFO top and streams them out
// over valid/ready, marking the final entry with output_last.
module lifo_drain_streamer
  import lifo_drain_streamer_pkg::*;
#(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned LENGTH_WIDTH = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    drain_start,
  input  logic [LENGTH_WIDTH-1:0] drain_length,
  output logic                    drain_busy,
  output logic                    drain_done,
  output logic [LENGTH_WIDTH-1:0] drain_count,
  input  logic                    lifo_empty,
  output logic                    lifo_read_enable,
  input  logic [WIDTH-1:0]        lifo_read_data,
  output logic                    output_valid,
  input  logic                    output_ready,
  output logic [WIDTH-1:0]        output_data,
  output logic                    output_last
);

  state_e                  state_q, state_d;
  logic [LENGTH_WIDTH-1:0] len_q, len_d;
  logic [LENGTH_WIDTH-1:0] count_q, count_d;
  logic                    done_q, done_d;

  logic       pop;
  logic       push_last;
  logic       tag_tail;
  logic       flush_done;
  logic       handshake;
  logic       buf_valid;
  logic       buf_last;
  logic [1:0] buf_count;

  assign handshake = buf_valid && output_ready;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    count_d    = count_q;
    done_d     = 1'b0;
    pop        = 1'b0;
    push_last  = 1'b0;
    tag_tail   = 1'b0;
    flush_done = 1'b0;
    case (state_q)
      StIdle: begin
        if (drain_start) begin
          count_d = '0;
          if (drain_length == '0) begin
            done_d = 1'b1;
          end else begin
            len_d   = drain_length;
            state_d = StPopping;
          end
        end
      end
      StPopping: begin
        if (!lifo_empty) begin
          if (count_q < len_q && (buf_count < 2'd2 || handshake)) begin
            pop     = 1'b1;
            count_d = count_q + 1'b1;
            if (count_d == len_q) begin
              push_last = 1'b1;
              state_d   = StFlushing;
            end
          end
        end else if (count_q != '0) begin
          tag_tail = 1'b1;
          state_d  = StFlushing;
        end else begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      StFlushing: begin
        if (handshake && buf_last) begin
          flush_done = 1'b1;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    // The LIFO must not lose an entry while this block is being reset.
    if (reset) begin
      pop = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      len_q   <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  lifo_drain_buffer #(
    .WIDTH(WIDTH)
  ) u_buffer (
    .clock        (clock),
    .reset        (reset),
    .push         (pop),
    .push_data    (lifo_read_data),
    .push_last    (push_last),
    .pop          (handshake),
    .tag_tail_last(tag_tail),
    .head_valid   (buf_valid),
    .head_data    (output_data),
    .head_last    (buf_last),
    .count        (buf_count)
  );

  assign lifo_read_enable = pop;
  assign output_valid     = buf_valid;
  assign output_last      = buf_last;
  assign drain_busy       = (state_q != StIdle);
  assign drain_done       = done_q || flush_done;
  assign drain_count      = count_q;

endmodule

// File: tb/tb_lifo_drain_streamer.sv
// Directed bench for lifo_drain_streamer with a behavioural LIFO and an
// output scoreboard.
module tb_lifo_drain_streamer;

  localparam int W  = 8;
  localparam int LW = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic          drain_start;
  logic [LW-1:0] drain_length;
  logic          drain_busy;
  logic          drain_done;
  logic [LW-1:0] drain_count;
  logic          lifo_empty;
  logic          lifo_read_enable;
  logic [W-1:0]  lifo_read_data;
  logic          output_valid;
  logic          output_ready;
  logic [W-1:0]  output_data;
  logic          output_last;

  lifo_drain_streamer #(
    .WIDTH       (W),
    .LENGTH_WIDTH(LW)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .drain_start     (drain_start),
    .drain_length    (drain_length),
    .drain_busy      (drain_busy),
    .drain_done      (drain_done),
    .drain_count     (drain_count),
    .lifo_empty      (lifo_empty),
    .lifo_read_enable(lifo_read_enable),
    .lifo_read_data  (lifo_read_data),
    .output_valid    (output_valid),
    .output_ready    (output_ready),
    .output_data     (output_data),
    .output_last     (output_last)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Behavioural LIFO with unregistered top-of-stack read.
  logic [W-1:0] mem [16];
  int           sp = 0;
  logic         load_req = 1'b0;
  int           load_n = 0;
  int           cyc = 0;

  assign lifo_empty     = (sp == 0);
  assign lifo_read_data = (sp > 0) ? mem[4'(sp - 1)] : '0;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (load_req) sp <= load_n;
    else if (lifo_read_enable && sp > 0) sp <= sp - 1;
  end

  // Scoreboard entries are {last, data}.
  logic [W:0] exp_q [$];

  int         outstanding = 0;
  int         done_cnt = 0;
  int         done_cyc = 0;
  int         pop_cnt = 0;
  logic       prev_stall = 1'b0;
  logic [W-1:0] prev_data = '0;
  logic       prev_last = 1'b0;
  logic [W:0] e;

  always @(negedge clock) begin
    if (reset) begin
      check("no_pop_in_reset", {31'd0, lifo_read_enable}, 32'd0);
      outstanding = 0;
      prev_stall  = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", {31'd0, output_valid}, 32'd1);
        check("stall_data", {24'd0, output_data}, {24'd0, prev_data});
        check("stall_last", {31'd0, output_last}, {31'd0, prev_last});
      end
      if (lifo_read_enable) begin
        check("pop_when_empty", {31'd0, lifo_empty}, 32'd0);
        pop_cnt++;
        outstanding++;
      end
      if (output_valid && output_ready) begin
        outstanding--;
        if (exp_q.size() == 0) begin
          check("unexpected_output", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("out_data", {24'd0, output_data}, {24'd0, e[W-1:0]});
          check("out_last", {31'd0, output_last}, {31'd0, e[W]});
        end
      end
      if (lifo_read_enable) check("buffer_bound", {31'd0, outstanding <= 2}, 32'd1);
      if (drain_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_stall = output_valid && !output_ready;
      prev_data  = output_data;
      prev_last  = output_last;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load(input int n, input int base);
    for (int i = 0; i < n; i++) mem[i[3:0]] = W'(base + i);
    load_req = 1'b1;
    load_n   = n;
    tick();
    load_req = 1'b0;
  endtask

  task automatic expect_drain(input int len);
    int n;
    n = (sp < len) ? sp : len;
    for (int k = 0; k < n; k++) exp_q.push_back({k == n - 1, mem[4'(sp - 1 - k)]});
  endtask

  // mode 0: ready held high; mode 1: ready follows 1,0,0,1,0,0,...
  task automatic run_drain(input string tag, input int len, input int mode, input int exp_lat);
    int d0;
    int k;
    int start_cyc;
    expect_drain(len);
    d0           = done_cnt;
    drain_length = LW'(len);
    drain_start  = 1'b1;
    output_ready = 1'b1;
    tick();
    drain_start = 1'b0;
    start_cyc   = cyc;
    check({tag, "_busy"}, {31'd0, drain_busy}, 32'd1);
    k = 1;
    for (int i = 0; i < 200 && done_cnt == d0; i++) begin
      output_ready = (mode == 0) ? 1'b1 : (k % 3 == 0);
      k++;
      tick();
    end
    check({tag, "_done_seen"}, done_cnt - d0, 32'd1);
    if (exp_lat >= 0) check({tag, "_latency"}, done_cyc - start_cyc, exp_lat);
    tick();
    check({tag, "_done_once"}, done_cnt - d0, 32'd1);
    check({tag, "_busy_drop"}, {31'd0, drain_busy}, 32'd0);
    check({tag, "_sb_empty"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    int p0;
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    reset        = 1'b1;
    drain_start  = 1'b0;
    drain_length = '0;
    output_ready = 1'b0;
    tick();
    tick();
    check("rst_busy", {31'd0, drain_busy}, 32'd0);
    check("rst_done", {31'd0, drain_done}, 32'd0);
    check("rst_count", {24'd0, drain_count}, 32'd0);
    check("rst_valid", {31'd0, output_valid}, 32'd0);
    check("rst_last", {31'd0, output_last}, 32'd0);
    check("rst_data", {24'd0, output_data}, 32'd0);
    reset = 1'b0;
    tick();

    // A..E with E on top, drain three.
    load(5, 'hA0);
    p0 = pop_cnt;
    run_drain("t1", 3, 0, 4);
    check("t1_count", {24'd0, drain_count}, 32'd3);
    check("t1_left", sp, 32'd2);
    check("t1_pops", pop_cnt - p0, 32'd3);
    check("t1_top", {24'd0, lifo_read_data}, 32'hA1);

    // Zero-length drain: done next cycle, never busy, no pop.
    p0           = pop_cnt;
    drain_length = '0;
    drain_start  = 1'b1;
    tick();
    drain_start = 1'b0;
    check("t2_done", {31'd0, drain_done}, 32'd1);
    check("t2_busy", {31'd0, drain_busy}, 32'd0);
    check("t2_count", {24'd0, drain_count}, 32'd0);
    tick();
    check("t2_done_pulse", {31'd0, drain_done}, 32'd0);
    check("t2_left", sp, 32'd2);
    check("t2_pops", pop_cnt - p0, 32'd0);

    // X then Y on top, length larger than contents.
    load(2, 'hB0);
    run_drain("t3", 8, 0, 3);
    check("t3_count", {24'd0, drain_count}, 32'd2);
    check("t3_left", sp, 32'd0);

    // Empty LIFO.
    p0 = pop_cnt;
    run_drain("t4", 4, 0, 1);
    check("t4_count", {24'd0, drain_count}, 32'd0);
    check("t4_pops", pop_cnt - p0, 32'd0);

    // Backpressure with ready 1,0,0 pattern.
    load(6, 'hC0);
    run_drain("t5", 6, 1, -1);
    check("t5_count", {24'd0, drain_count}, 32'd6);
    check("t5_left", sp, 32'd0);

    // Reset with two entries buffered; the reset cycle must not pop.
    load(5, 'hD0);
    expect_drain(5);
    drain_length = LW'(5);
    drain_start  = 1'b1;
    output_ready = 1'b0;
    tick();
    drain_start = 1'b0;
    tick();
    tick();
    check("t6_full_valid", {31'd0, output_valid}, 32'd1);
    reset        = 1'b1;
    output_ready = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    check("t6_valid", {31'd0, output_valid}, 32'd0);
    check("t6_last", {31'd0, output_last}, 32'd0);
    check("t6_data", {24'd0, output_data}, 32'd0);
    check("t6_rd_en", {31'd0, lifo_read_enable}, 32'd0);
    check("t6_busy", {31'd0, drain_busy}, 32'd0);
    check("t6_done", {31'd0, drain_done}, 32'd0);
    check("t6_count", {24'd0, drain_count}, 32'd0);
    check("t6_left", sp, 32'd3);
    run_drain("t7", 1, 0, 1);
    check("t7_count", {24'd0, drain_count}, 32'd1);
    check("t7_left", sp, 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
